// File: rtl/disp_scan.sv
// Debug readout: samples an 8-bit value, converts it to signed decimal with an
// iterative shift-add-3 engine and scans it onto a 4-digit active-low 7-segment display.
module disp_scan #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned REFRESH_DIV = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] val_i,
    input  logic       sgn_i,
    input  logic       req_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] an_o,
    output logic [6:0] seg_o
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned REF_W  = $clog2(REFRESH_DIV + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nx;
    logic [REF_W-1:0]  ref_cnt;
    logic              refresh_tick;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        dig_idx;
    logic [7:0]        mag;
    logic [11:0]       scratch;
    logic [11:0]       scratch_adj;
    logic [2:0]        iter;
    logic              neg_q;
    logic              pend;
    logic              trigger;
    logic [3:0]        disp_h, disp_t, disp_o;
    logic              disp_neg;
    logic              done_q;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    assign refresh_tick = (ref_cnt == REF_W'(REFRESH_DIV - 1));
    assign trigger      = req_i | pend | refresh_tick;

    // Free-running refresh and scan timebases; never stalled by conversions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else begin
            ref_cnt <= refresh_tick ? '0 : ref_cnt + 1'b1;
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                dig_idx  <= dig_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trigger) state_nx = SHIFT;
            SHIFT:   if (iter == 3'd7) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        scratch_adj = scratch;
        for (int unsigned i = 0; i < 3; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag      <= '0;
            scratch  <= '0;
            iter     <= '0;
            neg_q    <= 1'b0;
            pend     <= 1'b0;
            disp_h   <= '0;
            disp_t   <= '0;
            disp_o   <= '0;
            disp_neg <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        mag     <= (sgn_i & val_i[7]) ? 8'(-val_i) : val_i;
                        neg_q   <= sgn_i & val_i[7];
                        scratch <= '0;
                        iter    <= '0;
                        pend    <= 1'b0;
                    end
                end
                SHIFT: begin
                    {scratch, mag} <= {scratch_adj, mag} << 1;
                    iter           <= iter + 1'b1;
                end
                DONE: begin
                    disp_h   <= scratch[11:8];
                    disp_t   <= scratch[7:4];
                    disp_o   <= scratch[3:0];
                    disp_neg <= neg_q;
                end
                default: ;
            endcase
            // Requests arriving mid-conversion collapse into one follow-up run.
            if (state != IDLE && (req_i | refresh_tick))
                pend <= 1'b1;
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = done_q;
    assign an_o   = ~(4'b0001 << dig_idx);

    always_comb begin
        seg_o = 7'h7F;
        case (dig_idx)
            2'd0: seg_o = seg_code(disp_o);
            2'd1: seg_o = (disp_h == 4'd0 && disp_t == 4'd0) ? 7'h7F : seg_code(disp_t);
            2'd2: seg_o = (disp_h == 4'd0) ? 7'h7F : seg_code(disp_h);
            2'd3: seg_o = disp_neg ? 7'h3F : 7'h7F;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed self-checking bench for disp_scan with a short scan period and refresh interval.
module tb_disp_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] val_i = 8'h00;
    logic       sgn_i = 1'b0;
    logic       req_i = 1'b0;
    logic       busy_o;
    logic       done_o;
    logic [3:0] an_o;
    logic [6:0] seg_o;

    int checks = 0;
    int failures = 0;

    disp_scan #(.SCAN_DIV(4), .REFRESH_DIV(1000)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .val_i  (val_i),
        .sgn_i  (sgn_i),
        .req_i  (req_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .an_o   (an_o),
        .seg_o  (seg_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Request at edge T, scramble inputs afterwards, check the 9-cycle busy window and done pulse.
    task automatic run_conv(input string tag, input logic [7:0] v, input logic s);
        int bc;
        int dc;
        val_i = v;
        sgn_i = s;
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        val_i = ~v;
        sgn_i = ~s;
        bc = busy_o ? 1 : 0;
        dc = done_o ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy_o) bc++;
            if (done_o) dc++;
        end
        check({tag, "_busy_len"}, bc, 9);
        check({tag, "_early_done"}, dc, 0);
        tick();
        check({tag, "_done_T9"}, done_o, 1);
        check({tag, "_busy_T9"}, busy_o, 0);
        tick();
        check({tag, "_done_T10"}, done_o, 0);
    endtask

    task automatic read_digit(input string tag, input int idx, input logic [6:0] exp);
        logic [3:0] want;
        want = ~(4'b0001 << idx);
        for (int n = 0; n < 40; n++) begin
            if (an_o == want) break;
            tick();
        end
        check({tag, "_an"}, an_o, want);
        check({tag, "_seg"}, seg_o, exp);
    endtask

    task automatic show(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0);
        read_digit({tag, "_d0"}, 0, e0);
        read_digit({tag, "_d1"}, 1, e1);
        read_digit({tag, "_d2"}, 2, e2);
        read_digit({tag, "_d3"}, 3, e3);
    endtask

    initial begin
        int dc;
        int first_done;
        int second_done;

        // Reset state and scan rotation.
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_an", an_o, 4'b1110);
        check("rst_seg", seg_o, 7'h40);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] exp_an;
            tick();
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("scan_k%0d", k), an_o, exp_an);
        end

        do_reset();
        run_conv("u200", 8'd200, 1'b0);
        show("u200", 7'h7F, 7'h24, 7'h40, 7'h40);

        do_reset();
        run_conv("sF9", 8'hF9, 1'b1);
        show("sF9", 7'h3F, 7'h7F, 7'h7F, 7'h78);

        do_reset();
        run_conv("s80", 8'h80, 1'b1);
        show("s80", 7'h3F, 7'h79, 7'h24, 7'h00);

        do_reset();
        run_conv("uFF", 8'hFF, 1'b0);
        show("uFF", 7'h7F, 7'h24, 7'h12, 7'h12);

        do_reset();
        run_conv("z00", 8'h00, 1'b1);
        show("z00", 7'h7F, 7'h7F, 7'h7F, 7'h40);

        // Overlap: request held three edges; value changes afterwards.
        do_reset();
        val_i = 8'd100;
        sgn_i = 1'b0;
        req_i = 1'b1;
        tick();                // edge T
        dc = 0;
        first_done = -1;
        second_done = -1;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin
                req_i = 1'b0;
                val_i = 8'd5;
            end
            tick();            // edge T+c
            if (c == 10) check("ovl_busy_T10", busy_o, 1);
            if (done_o) begin
                dc++;
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
        end
        check("ovl_done_count", dc, 2);
        check("ovl_first_done", first_done, 9);
        check("ovl_second_done", second_done, 19);
        show("ovl", 7'h7F, 7'h7F, 7'h7F, 7'h12);

        // Reset mid-conversion.
        do_reset();
        val_i = 8'd99;
        sgn_i = 1'b0;
        req_i = 1'b1;
        tick();                // edge T
        req_i = 1'b1;          // pending request to be discarded by reset
        tick();
        req_i = 1'b0;
        tick();
        tick();                // edge T+3
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy_o, 0);
        check("mrst_an", an_o, 4'b1110);
        check("mrst_seg", seg_o, 7'h40);
        tick();
        tick();
        rst_n = 1'b1;
        dc = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done_o) dc++;
        end
        check("mrst_no_done", dc, 0);
        check("mrst_idle", busy_o, 0);
        run_conv("post42", 8'd42, 1'b0);
        show("post42", 7'h7F, 7'h7F, 7'h19, 7'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
